// File: rtl/shift_add_mult_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around an 8-bit ripple-carry adder.
// One partial-product iteration per clock, eight iterations per operation, fixed latency.

module rca_8bit (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fa
            assign sum[gi]       = in1[gi] ^ in2[gi] ^ carry[gi];
            assign carry[gi + 1] = (in1[gi] & in2[gi]) | (carry[gi] & (in1[gi] ^ in2[gi]));
        end
    endgenerate

    assign cout = carry[8];
endmodule

module shift_add_mult_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [2:0]  cnt_reg;
    logic [7:0]  mcand_reg;
    logic [15:0] p_reg;
    logic [15:0] p_next;
    logic [15:0] product_reg;

    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        cout;

    assign addend = p_reg[0] ? mcand_reg : 8'h00;

    rca_8bit u_rca (
        .in1  (p_reg[15:8]),
        .in2  (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The adder carry becomes the new MSB so large products are not truncated.
    assign p_next = {cout, sum, p_reg[7:1]};

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            mcand_reg   <= 8'h00;
            p_reg       <= 16'h0000;
            product_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg <= multiplicand;
                        p_reg     <= {8'h00, multiplier};
                        cnt_reg   <= 3'd0;
                    end
                end
                RUN: begin
                    p_reg   <= p_next;
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        product_reg <= p_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = product_reg;
endmodule
